// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage: widens an IN_W-bit immediate to OUT_W bits
// (sign / zero / upper / branch-offset) behind a valid/ready handshake. An output
// register plus one skid entry absorb a cycle of back-pressure without dropping data.
module imm_extend_stage #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned SHIFT_BR = 2,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_neg
);

  // Reject parameter sets the datapath cannot represent.
  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_extend_stage: IN_W must be at least 2");
  end
  if (OUT_W <= IN_W) begin : g_bad_out_w
    $error("imm_extend_stage: OUT_W must exceed IN_W");
  end else if (SHIFT_BR > OUT_W - IN_W) begin : g_bad_shift
    $error("imm_extend_stage: SHIFT_BR must not exceed OUT_W - IN_W");
  end
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("imm_extend_stage: TAG_W must be at least 1");
  end

  localparam int unsigned PadW = OUT_W - IN_W;
  // Stored entry layout: {neg, tag, data}.
  localparam int unsigned EntW = OUT_W + TAG_W + 1;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [EntW-1:0]   or_q, or_d;
  logic [EntW-1:0]   sk_q, sk_d;

  logic [OUT_W-1:0]  sext;
  logic [OUT_W-1:0]  ext_data;
  logic              ext_neg;
  logic [EntW-1:0]   new_ent;
  logic              accept;
  logic              out_hs;

  // Extend the incoming immediate; only used when the item is accepted.
  always_comb begin
    sext     = {{PadW{in_imm[IN_W-1]}}, in_imm};
    ext_data = sext;
    ext_neg  = 1'b0;
    case (in_mode)
      2'b00: begin
        ext_data = sext;
        ext_neg  = in_imm[IN_W-1];
      end
      2'b01:   ext_data = {{PadW{1'b0}}, in_imm};
      2'b10:   ext_data = {in_imm, {PadW{1'b0}}};
      2'b11: begin
        // Upper bits shifted out are dropped by the OUT_W-wide result.
        ext_data = sext << SHIFT_BR;
        ext_neg  = in_imm[IN_W-1];
      end
      default: ext_data = sext;
    endcase
    new_ent = {ext_neg, in_tag, ext_data};
  end

  // Ready depends only on state, flush and reset, never on out_ready.
  always_comb begin
    in_ready = ~reset & ~flush & (state_q != StTwo);
  end

  // Next-state for the OR/SK pair; the skid always drains into OR before newer items.
  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sk_d    = sk_q;
    accept  = in_valid & in_ready;
    out_hs  = out_valid_q & out_ready;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          or_d    = new_ent;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && out_hs) begin
          or_d = new_ent;
        end else if (accept) begin
          sk_d    = new_ent;
          state_d = StTwo;
        end else if (out_hs) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_hs) begin
          or_d    = sk_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Squash discards everything held; a same-cycle output handshake has already happened.
    if (flush) begin
      state_d = StEmpty;
    end
    out_valid_d = (state_d != StEmpty);
  end

  // State and storage registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      or_q        <= '0;
      sk_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      or_q        <= or_d;
      sk_q        <= sk_d;
    end
  end

  // Outputs come straight from the output register.
  always_comb begin
    out_valid = out_valid_q;
    out_data  = or_q[OUT_W-1:0];
    out_tag   = or_q[OUT_W +: TAG_W];
    out_neg   = or_q[EntW-1];
  end

endmodule
